cmd_loader: RTL and testbench
=============================

Name: cmd_loader

Overview:
- Sits directly downstream of the SPI data_io stage and consumes its clk-domain byte-write stream (wr/addr/data, downloading, index).
- For the menu index selecting /CMD files, it parses the TRS-80 /CMD record format: load blocks, transfer address, and skipped records.
- It converts load-block payload into Z80 memory writes and captures the entry address.
- For all other indices it passes raw bytes straight through to the 16-bit memory port.

Parameters:
- CMD_INDEX, 5'd1, menu index whose downloads are parsed as /CMD.
- RAW_BASE, 16'h0000, offset added to in_addr[15:0] in raw pass-through mode.

Ports:
- clk  in  1  system clock, same domain as data_io wr.
- reset_n  in  1  asynchronous active-low reset.
- downloading  in  1  download-active level from data_io; SPI domain, synchronised here.
- index  in  5  menu index from data_io; sampled on the synchronised downloading rise.
- in_wr  in  1  one-cycle byte strobe from data_io.
- in_addr  in  25  byte address from data_io; used only in raw mode.
- in_data  in  8  byte value, valid while in_wr is high.
- mem_wr  out  1  one-cycle write strobe to Z80 RAM.
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- busy  out  1  high while a download is being consumed.
- exec_addr  out  16  entry address from the transfer record.
- exec_valid  out  1  level; a transfer record was parsed in the last /CMD load.
- load_err  out  1  level; the last /CMD load was malformed.

Behaviour:
- Reset: all outputs 0 and state IDLE.
- downloading passes through a 2-FF synchroniser, followed by edge detection.
- Start (synchronised rise):
  - Latch mode = (index == CMD_INDEX).
  - Clear exec_valid and load_err, and set busy.
  - In /CMD mode go to TYPE; otherwise go to RAW.
- Bytes are consumed only on in_wr. There is no backpressure: data_io guarantees at least 8 clk cycles between strobes.
- Output latency: mem_wr is asserted exactly 1 clk after the in_wr that carries the byte, with mem_addr/mem_data registered alongside it.
- RAW: mem_addr = in_addr[15:0] + RAW_BASE, truncated to 16 bits (wraps). Every byte is written.
- TYPE:
  - 8'h01 -> LEN1.
  - 8'h02 -> XLEN.
  - Any other value -> SLEN.
- LEN1:
  - cnt(9 bits) = {1'b0, len - 8'd2}; if the 8-bit result is 0, cnt = 256. So len 0/1/2 give 254/255/256 data bytes.
  - Then go to ALO.
- ALO/AHI: load the pointer low byte, then the high byte; then go to DATA.
- DATA:
  - On each byte, write it at the pointer, increment the pointer (wraps at 16'hFFFF -> 0), and decrement cnt.
  - When cnt reaches 0, return to TYPE.
- XLEN: the length byte is ignored; go to XLO.
- XLO/XHI: capture exec_addr; set exec_valid; go to DONE.
- SLEN: cnt = len, with 0 meaning 256; go to SKIP.
- SKIP: discard cnt bytes, then go to TYPE.
- DONE: any further byte sets load_err and is otherwise ignored (trailing padding is tolerated only if absent).
- End (synchronised fall):
  - busy -> 0 and go to IDLE.
  - In /CMD mode, load_err is set if the state is anything other than TYPE or DONE (truncated record).
- Start while busy (new rise without an intervening fall, e.g. after a glitch): restart cleanly as a new start.
- in_wr arriving in IDLE: ignored.
- In_wr and an end edge in the same cycle: the byte is processed first, then IDLE.
- reset_n asserted mid-load: immediate return to reset values.

Optional Feature:
- Macro: CMDLOAD_AUTORUN_EN.
- When defined, add output run_req (1 bit): a one-cycle pulse 1 clk after the end edge, if exec_valid is set and load_err is clear. The CPU glue uses it to jump to exec_addr.
- When undefined, there is no run_req port and no pulse logic.

Decomposition:
- Package cmd_loader_pkg holds:
  - the state enum;
  - record-type constants REC_LOAD = 8'h01, REC_XFER = 8'h02;
  - the len-to-count conversion function.
- Sub-module sync_edge (2-FF synchroniser plus rise/fall pulses) is used for downloading.

Test Plan:
- Raw mode: index = 0, bytes AA, BB at in_addr 0/1, RAW_BASE = 0 -> mem_wr pulses 1 clk after each in_wr, writing 0000 = AA and 0001 = BB; exec_valid stays 0.
- Simple /CMD: 01 05 00 52 11 22 33, then 02 02 00 52, then fall -> writes 5200 = 11, 5201 = 22, 5202 = 33; exec_addr = 5200; exec_valid = 1; load_err = 0.
- Length wrap: 01 02 00 80 + 256 bytes -> 256 writes covering 8000..80FF. Separately, 01 00 FE FF + 254 bytes -> pointer wraps, last write at 00FB.
- Skip record: 05 03 41 42 43, then 01 03 00 60 7E -> only 6000 = 7E is written; SKIP emits no mem_wr.
- Truncation: 01 06 00 70 01, then fall -> one write 7000 = 01; load_err = 1; busy = 0.
- Reset mid-DATA: assert reset_n low during DATA -> all outputs 0 immediately; the next start parses from TYPE. With CMDLOAD_AUTORUN_EN, the simple-/CMD case gives a single run_req pulse after the fall.

Source files
------------

// File: rtl/cmd_loader_pkg.sv
// cmd_loader_pkg: shared types and helpers for the /CMD loader.
//   state_t     - parser state encoding
//   REC_LOAD    - /CMD load-block record type
//   REC_XFER    - /CMD transfer-address record type
//   len_to_cnt  - record length byte to payload byte count (0 means 256)
package cmd_loader_pkg;

    localparam logic [7:0] REC_LOAD = 8'h01;
    localparam logic [7:0] REC_XFER = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RAW,
        ST_TYPE,
        ST_LEN1,
        ST_ALO,
        ST_AHI,
        ST_DATA,
        ST_XLEN,
        ST_XLO,
        ST_XHI,
        ST_SLEN,
        ST_SKIP,
        ST_DONE
    } state_t;

    // The length byte counts overhead bytes (ovh) that are not payload.
    // An 8-bit remainder of zero stands for a full 256-byte block.
    function automatic logic [8:0] len_to_cnt(input logic [7:0] len, input logic [7:0] ovh);
        logic [7:0] d;
        d = len - ovh;
        return (d == 8'd0) ? 9'd256 : {1'b0, d};
    endfunction

endpackage

// File: rtl/cmd_loader_if.sv
// cmd_loader_if: byte stream from data_io plus the Z80 memory write port.
//   downloading, index, in_wr, in_addr, in_data - from data_io (master drives)
//   mem_wr, mem_addr, mem_data                  - write port (slave drives)
interface cmd_loader_if;
    logic        downloading;
    logic [4:0]  index;
    logic        in_wr;
    logic [24:0] in_addr;
    logic [7:0]  in_data;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;

    modport master (
        output downloading, index, in_wr, in_addr, in_data,
        input  mem_wr, mem_addr, mem_data
    );

    modport slave (
        input  downloading, index, in_wr, in_addr, in_data,
        output mem_wr, mem_addr, mem_data
    );
endinterface

// File: rtl/cmd_loader_sync_edge.sv
// sync_edge: 2-FF synchroniser for a slow level, with rise/fall pulses.
//   clk, reset_n - clock and asynchronous active-low reset
//   d            - asynchronous input level
//   rise, fall   - one-cycle pulses on synchronised edges
module sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    // sr[1] is the synchronised level, sr[2] its previous value.
    logic [2:0] sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= {sr[1:0], d};
    end

    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/cmd_loader.sv
// cmd_loader: consumes the data_io byte stream. For index CMD_INDEX it parses
// TRS-80 /CMD records into Z80 RAM writes and captures the transfer address;
// for any other index bytes go straight to memory at in_addr + RAW_BASE.
//   clk, reset_n   - clock, asynchronous active-low reset
//   bus (slave)    - data_io byte stream in, memory write port out
//   busy           - download being consumed
//   exec_addr      - entry address from the transfer record
//   exec_valid     - transfer record seen in the last /CMD load
//   load_err       - last /CMD load malformed
//   run_req        - only with CMDLOAD_AUTORUN_EN: pulse 1 clk after end of a
//                    clean load that had a transfer record
module cmd_loader
    import cmd_loader_pkg::*;
#(
    parameter logic [4:0]  CMD_INDEX = 5'd1,
    parameter logic [15:0] RAW_BASE  = 16'h0000
) (
    input  logic         clk,
    input  logic         reset_n,
    cmd_loader_if.slave  bus,
    output logic         busy,
    output logic [15:0]  exec_addr,
    output logic         exec_valid,
`ifdef CMDLOAD_AUTORUN_EN
    output logic         run_req,
`endif
    output logic         load_err
);
    logic        rise, fall;
    state_t      state, state_n;
    logic        cmd_mode, cmd_mode_n;
    logic [8:0]  cnt, cnt_n;
    logic [15:0] ptr, ptr_n;
    logic [15:0] exec_addr_n;
    logic        exec_valid_n, load_err_n, busy_n;
    logic        mem_wr_n;
    logic [15:0] mem_addr_n;
    logic [7:0]  mem_data_n;
    logic        run_n;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.in_addr[24:16];

    sync_edge u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.downloading),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cmd_mode     <= 1'b0;
            cnt          <= '0;
            ptr          <= '0;
            exec_addr    <= '0;
            exec_valid   <= 1'b0;
            load_err     <= 1'b0;
            busy         <= 1'b0;
            bus.mem_wr   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
`ifdef CMDLOAD_AUTORUN_EN
            run_req      <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            cmd_mode     <= cmd_mode_n;
            cnt          <= cnt_n;
            ptr          <= ptr_n;
            exec_addr    <= exec_addr_n;
            exec_valid   <= exec_valid_n;
            load_err     <= load_err_n;
            busy         <= busy_n;
            bus.mem_wr   <= mem_wr_n;
            bus.mem_addr <= mem_addr_n;
            bus.mem_data <= mem_data_n;
`ifdef CMDLOAD_AUTORUN_EN
            run_req      <= run_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        cmd_mode_n   = cmd_mode;
        cnt_n        = cnt;
        ptr_n        = ptr;
        exec_addr_n  = exec_addr;
        exec_valid_n = exec_valid;
        load_err_n   = load_err;
        busy_n       = busy;
        mem_wr_n     = 1'b0;
        mem_addr_n   = bus.mem_addr;
        mem_data_n   = bus.mem_data;
        run_n        = 1'b0;

        if (rise) begin
            // A rise always restarts, even mid-load.
            cmd_mode_n   = (bus.index == CMD_INDEX);
            exec_valid_n = 1'b0;
            load_err_n   = 1'b0;
            busy_n       = 1'b1;
            state_n      = (bus.index == CMD_INDEX) ? ST_TYPE : ST_RAW;
        end else begin
            if (bus.in_wr) begin
                case (state)
                    ST_IDLE: ;
                    ST_RAW: begin
                        mem_wr_n   = 1'b1;
                        mem_addr_n = bus.in_addr[15:0] + RAW_BASE;
                        mem_data_n = bus.in_data;
                    end
                    ST_TYPE: begin
                        if (bus.in_data == REC_LOAD)      state_n = ST_LEN1;
                        else if (bus.in_data == REC_XFER) state_n = ST_XLEN;
                        else                              state_n = ST_SLEN;
                    end
                    ST_LEN1: begin
                        // Length includes the two address bytes.
                        cnt_n   = len_to_cnt(bus.in_data, 8'd2);
                        state_n = ST_ALO;
                    end
                    ST_ALO: begin
                        ptr_n[7:0] = bus.in_data;
                        state_n    = ST_AHI;
                    end
                    ST_AHI: begin
                        ptr_n[15:8] = bus.in_data;
                        state_n     = ST_DATA;
                    end
                    ST_DATA: begin
                        mem_wr_n   = 1'b1;
                        mem_addr_n = ptr;
                        mem_data_n = bus.in_data;
                        ptr_n      = ptr + 16'd1;
                        cnt_n      = cnt - 9'd1;
                        if (cnt == 9'd1) state_n = ST_TYPE;
                    end
                    ST_XLEN: state_n = ST_XLO;
                    ST_XLO: begin
                        exec_addr_n[7:0] = bus.in_data;
                        state_n          = ST_XHI;
                    end
                    ST_XHI: begin
                        exec_addr_n[15:8] = bus.in_data;
                        exec_valid_n      = 1'b1;
                        state_n           = ST_DONE;
                    end
                    ST_SLEN: begin
                        cnt_n   = len_to_cnt(bus.in_data, 8'd0);
                        state_n = ST_SKIP;
                    end
                    ST_SKIP: begin
                        cnt_n = cnt - 9'd1;
                        if (cnt == 9'd1) state_n = ST_TYPE;
                    end
                    ST_DONE: load_err_n = 1'b1;
                    default: state_n = ST_IDLE;
                endcase
            end

            // End is judged on the state after any byte in this same cycle.
            if (fall && state != ST_IDLE) begin
                busy_n = 1'b0;
                if (cmd_mode && state_n != ST_TYPE && state_n != ST_DONE)
                    load_err_n = 1'b1;
                run_n   = exec_valid_n & ~load_err_n;
                state_n = ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cmd_loader.sv
// tb_cmd_loader: directed bench for cmd_loader. Expected memory writes are
// queued by the stimulus and checked by an independent monitor.
module tb_cmd_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, exec_valid, load_err;
    logic [15:0] exec_addr;
`ifdef CMDLOAD_AUTORUN_EN
    logic run_req;
    int unsigned run_cnt = 0;
`endif

    always #5 clk = ~clk;

    cmd_loader_if bus();

    cmd_loader #(.CMD_INDEX(5'd1), .RAW_BASE(16'h0000)) dut (
        .clk        (clk),
        .reset_n    (rst_n),
        .bus        (bus),
        .busy       (busy),
        .exec_addr  (exec_addr),
        .exec_valid (exec_valid),
`ifdef CMDLOAD_AUTORUN_EN
        .run_req    (run_req),
`endif
        .load_err   (load_err)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int unsigned cyc;
    } exp_t;

    exp_t sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    logic [24:0] aux = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every mem_wr must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.mem_wr === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got %h=%h expected no write", bus.mem_addr, bus.mem_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("mem_addr", {16'h0, bus.mem_addr}, {16'h0, e.a});
                check("mem_data", {24'h0, bus.mem_data}, {24'h0, e.d});
                check("mem_wr_latency", cyc, e.cyc);
            end
        end
`ifdef CMDLOAD_AUTORUN_EN
        if (rst_n && run_req === 1'b1) run_cnt++;
`endif
    end

    task automatic send(input logic [24:0] a, input logic [7:0] d, input bit wr, input logic [15:0] ea);
        @(negedge clk);
        if (wr) sbq.push_back('{a: ea, d: d, cyc: cyc + 1});
        bus.in_wr   = 1'b1;
        bus.in_addr = a;
        bus.in_data = d;
        @(negedge clk);
        bus.in_wr = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cb(input logic [7:0] d);
        aux = aux + 25'd1;
        send(aux, d, 1'b0, 16'h0);
    endtask

    task automatic cw(input logic [7:0] d, input logic [15:0] ea);
        aux = aux + 25'd1;
        send(aux, d, 1'b1, ea);
    endtask

    task automatic start_dl(input logic [4:0] idx);
        @(negedge clk);
        bus.index       = idx;
        bus.downloading = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic end_dl();
        @(negedge clk);
        bus.downloading = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        bus.downloading = 1'b0;
        bus.index       = '0;
        bus.in_wr       = 1'b0;
        bus.in_addr     = '0;
        bus.in_data     = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_exec_valid", {31'h0, exec_valid}, 32'h0);
        check("rst_load_err", {31'h0, load_err}, 32'h0);
        check("rst_exec_addr", {16'h0, exec_addr}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Raw pass-through
        start_dl(5'd0);
        check("raw_busy", {31'h0, busy}, 32'h1);
        send(25'd0, 8'hAA, 1'b1, 16'h0000);
        send(25'd1, 8'hBB, 1'b1, 16'h0001);
        end_dl();
        check("raw_busy_end", {31'h0, busy}, 32'h0);
        check("raw_exec_valid", {31'h0, exec_valid}, 32'h0);

        // Byte while idle is ignored
        send(25'd3, 8'h99, 1'b0, 16'h0);

        // Simple /CMD
`ifdef CMDLOAD_AUTORUN_EN
        run_cnt = 0;
`endif
        start_dl(5'd1);
        cb(8'h01); cb(8'h05); cb(8'h00); cb(8'h52);
        cw(8'h11, 16'h5200); cw(8'h22, 16'h5201); cw(8'h33, 16'h5202);
        cb(8'h02); cb(8'h02); cb(8'h00); cb(8'h52);
        end_dl();
        check("cmd_exec_addr", {16'h0, exec_addr}, 32'h5200);
        check("cmd_exec_valid", {31'h0, exec_valid}, 32'h1);
        check("cmd_load_err", {31'h0, load_err}, 32'h0);
        check("cmd_busy", {31'h0, busy}, 32'h0);
`ifdef CMDLOAD_AUTORUN_EN
        check("run_req_pulses", run_cnt, 32'd1);
`endif

        // 256-byte block (len 2)
        start_dl(5'd1);
        check("wrap_exec_valid_cleared", {31'h0, exec_valid}, 32'h0);
        cb(8'h01); cb(8'h02); cb(8'h00); cb(8'h80);
        for (int i = 0; i < 256; i++) cw(i[7:0], 16'h8000 + i[15:0]);
        end_dl();
        check("len256_load_err", {31'h0, load_err}, 32'h0);

        // 254-byte block (len 0) with pointer wrap
        start_dl(5'd1);
        cb(8'h01); cb(8'h00); cb(8'hFE); cb(8'hFF);
        for (int i = 0; i < 254; i++) cw(i[7:0] ^ 8'h5A, 16'hFFFE + i[15:0]);
        end_dl();
        check("len254_load_err", {31'h0, load_err}, 32'h0);

        // Skip record then load
        start_dl(5'd1);
        cb(8'h05); cb(8'h03); cb(8'h41); cb(8'h42); cb(8'h43);
        cb(8'h01); cb(8'h03); cb(8'h00); cb(8'h60);
        cw(8'h7E, 16'h6000);
        end_dl();
        check("skip_load_err", {31'h0, load_err}, 32'h0);

        // Truncated load block
        start_dl(5'd1);
        cb(8'h01); cb(8'h06); cb(8'h00); cb(8'h70);
        cw(8'h01, 16'h7000);
        end_dl();
        check("trunc_load_err", {31'h0, load_err}, 32'h1);
        check("trunc_busy", {31'h0, busy}, 32'h0);

        // Trailing byte after transfer record
        start_dl(5'd1);
        cb(8'h02); cb(8'h02); cb(8'h34); cb(8'h12);
        check("done_no_err_yet", {31'h0, load_err}, 32'h0);
        cb(8'h00);
        check("done_trailing_err", {31'h0, load_err}, 32'h1);
        end_dl();
        check("done_exec_addr", {16'h0, exec_addr}, 32'h1234);
        check("done_exec_valid", {31'h0, exec_valid}, 32'h1);

        // Last byte coincides with the end edge
        start_dl(5'd1);
        cb(8'h01); cb(8'h04); cb(8'h00); cb(8'h90);
        cw(8'hAA, 16'h9000);
        @(negedge clk);
        bus.downloading = 1'b0;
        repeat (2) @(negedge clk);
        sbq.push_back('{a: 16'h9001, d: 8'hBB, cyc: cyc + 1});
        bus.in_wr   = 1'b1;
        bus.in_data = 8'hBB;
        @(negedge clk);
        bus.in_wr = 1'b0;
        repeat (6) @(negedge clk);
        check("coinc_load_err", {31'h0, load_err}, 32'h0);
        check("coinc_busy", {31'h0, busy}, 32'h0);

        // Reset mid-DATA
        start_dl(5'd1);
        cb(8'h01); cb(8'h05); cb(8'h00); cb(8'hA0);
        cw(8'h11, 16'hA000);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
        check("mid_rst_mem_data", {24'h0, bus.mem_data}, 32'h0);
        check("mid_rst_exec_addr", {16'h0, exec_addr}, 32'h0);
        check("mid_rst_exec_valid", {31'h0, exec_valid}, 32'h0);
        bus.downloading = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        start_dl(5'd1);
        cb(8'h01); cb(8'h04); cb(8'h00); cb(8'hB0);
        cw(8'h5A, 16'hB000); cw(8'h5B, 16'hB001);
        end_dl();
        check("post_rst_load_err", {31'h0, load_err}, 32'h0);

        repeat (5) @(negedge clk);
        check("sb_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
